// File: rtl/coralnpu_cosim_retire_buffer.sv
// Retire capture buffer: compacts up to NUM_RETIRE retired instructions per cycle into a
// circular FIFO, tags each one with a sequence number and hands them to the cosim driver one at a time.
module coralnpu_cosim_retire_buffer #(
    parameter int NUM_RETIRE = 4,
    parameter int DEPTH      = 16,
    parameter int XLEN       = 32,
    parameter int SEQ_W      = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_RETIRE-1:0]        retire_valid_i,
    input  logic [NUM_RETIRE*XLEN-1:0]   retire_pc_i,
    input  logic [NUM_RETIRE*XLEN-1:0]   retire_insn_i,
    input  logic                         halt_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [XLEN-1:0]              out_pc_o,
    output logic [XLEN-1:0]              out_insn_o,
    output logic [SEQ_W-1:0]             out_seq_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         overflow_o,
    output logic [15:0]                  drop_count_o,
    output logic                         done_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  pc_mem   [DEPTH];
    logic [XLEN-1:0]  insn_mem [DEPTH];
    logic [SEQ_W-1:0] seq_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [SEQ_W-1:0] seq;
    logic             overflow;
    logic [15:0]      drop_count;
    logic             halt_q;
    logic             done_q;

    logic [CNT_W-1:0] n_in;
    logic [CNT_W-1:0] lane_off [NUM_RETIRE];
    logic [PTR_W-1:0] wr_idx   [NUM_RETIRE];
    logic [CNT_W-1:0] free;
    logic             accept;
    logic             do_write;
    logic             do_drop;
    logic             pop;
    logic [CNT_W-1:0] count_next;
    logic [16:0]      drop_sum;

    // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
    always_comb begin
        n_in = '0;
        for (int i = 0; i < NUM_RETIRE; i++) begin
            lane_off[i] = n_in;
            n_in        = n_in + CNT_W'(retire_valid_i[i]);
        end
    end

    for (genvar g = 0; g < NUM_RETIRE; g++) begin : g_wr_idx
        logic [CNT_W-1:0] slot_sum;
        assign slot_sum  = {1'b0, wr_ptr} + lane_off[g];
        assign wr_idx[g] = slot_sum[PTR_W-1:0];
    end

    // Groups are all-or-nothing against the pre-pop occupancy; after halt nothing is taken.
    always_comb begin
        free       = CNT_W'(DEPTH) - count;
        accept     = !halt_q && (n_in != '0);
        do_write   = accept && (n_in <= free);
        do_drop    = accept && (n_in > free);
        pop        = (count != '0) && out_ready_i;
        count_next = count + (do_write ? n_in : '0) - CNT_W'(pop);
        drop_sum   = {1'b0, drop_count} + 17'(n_in);
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            for (int i = 0; i < NUM_RETIRE; i++) begin
                if (retire_valid_i[i]) begin
                    pc_mem[wr_idx[i]]   <= retire_pc_i[i*XLEN +: XLEN];
                    insn_mem[wr_idx[i]] <= retire_insn_i[i*XLEN +: XLEN];
                    seq_mem[wr_idx[i]]  <= seq + SEQ_W'(lane_off[i]);
                end
            end
        end
    end

    // Sequence numbers advance on drops as well, so the driver can see the gap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            halt_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + n_in[PTR_W-1:0];
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            if (accept) begin
                seq <= seq + SEQ_W'(n_in);
            end
            if (do_drop) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
            halt_q <= halt_q | halt_i;
            done_q <= done_q | (halt_q && (count == '0) && !do_write);
        end
    end

    assign out_valid_o  = (count != '0);
    assign out_pc_o     = out_valid_o ? pc_mem[rd_ptr]   : '0;
    assign out_insn_o   = out_valid_o ? insn_mem[rd_ptr] : '0;
    assign out_seq_o    = out_valid_o ? seq_mem[rd_ptr]  : '0;
    assign count_o      = count;
    assign overflow_o   = overflow;
    assign drop_count_o = drop_count;
    assign done_o       = done_q;

endmodule

// File: tb/tb_coralnpu_cosim_retire_buffer.sv
// Directed bench for the retire buffer: compaction, sequencing, overflow, halt/drain and async reset,
// all against hand-computed expectations.
module tb_coralnpu_cosim_retire_buffer;

    logic          clk_i;
    logic          rst_ni;
    logic [3:0]    retire_valid_i;
    logic [127:0]  retire_pc_i;
    logic [127:0]  retire_insn_i;
    logic          halt_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [31:0]   out_pc_o;
    logic [31:0]   out_insn_o;
    logic [31:0]   out_seq_o;
    logic [4:0]    count_o;
    logic          overflow_o;
    logic [15:0]   drop_count_o;
    logic          done_o;

    int errorCount;
    int checkCount;

    coralnpu_cosim_retire_buffer #(
        .NUM_RETIRE(4), .DEPTH(16), .XLEN(32), .SEQ_W(32)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .retire_valid_i(retire_valid_i), .retire_pc_i(retire_pc_i),
        .retire_insn_i(retire_insn_i), .halt_i(halt_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_insn_o(out_insn_o), .out_seq_o(out_seq_o),
        .count_o(count_o), .overflow_o(overflow_o),
        .drop_count_o(drop_count_o), .done_o(done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mkInsn(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, and return at posedge+1 for sampling.
    task automatic applyStimulus(input logic [3:0] valid, input logic [127:0] pcs,
                                 input logic halt, input logic ready);
        retire_valid_i = valid;
        retire_pc_i    = pcs;
        for (int l = 0; l < 4; l++) retire_insn_i[l*32 +: 32] = mkInsn(pcs[l*32 +: 32]);
        halt_i         = halt;
        out_ready_i    = ready;
        @(posedge clk_i);
        #1;
        retire_valid_i = '0;
        halt_i         = 1'b0;
        out_ready_i    = 1'b0;
    endtask

    task automatic idle(input logic ready);
        applyStimulus(4'b0000, 128'h0, 1'b0, ready);
    endtask

    task automatic fillGroup(input int g);
        logic [127:0] p;
        for (int l = 0; l < 4; l++) p[l*32 +: 32] = 32'(32'h1000 + 16*g + 4*l);
        applyStimulus(4'b1111, p, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        retire_valid_i = '0;
        halt_i = 1'b0;
        out_ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        rst_ni = 1'b0;
        retire_valid_i = '0;
        retire_pc_i = '0;
        retire_insn_i = '0;
        halt_i = 1'b0;
        out_ready_i = 1'b0;
        #3;
        checkOutput("reset count", 64'(count_o), 64'd0);
        checkOutput("reset valid", 64'(out_valid_o), 64'd0);
        checkOutput("reset overflow", 64'(overflow_o), 64'd0);
        checkOutput("reset drops", 64'(drop_count_o), 64'd0);
        checkOutput("reset done", 64'(done_o), 64'd0);
        checkOutput("reset pc", 64'(out_pc_o), 64'd0);
        checkOutput("reset seq", 64'(out_seq_o), 64'd0);
        doReset();

        // Single lane, one-cycle latency, then pop back to empty
        applyStimulus(4'b0001, {96'h0, 32'h8000_0000}, 1'b0, 1'b0);
        checkOutput("single valid", 64'(out_valid_o), 64'd1);
        checkOutput("single pc", 64'(out_pc_o), 64'h8000_0000);
        checkOutput("single insn", 64'(out_insn_o), 64'h25A5_0000);
        checkOutput("single seq", 64'(out_seq_o), 64'd0);
        checkOutput("single count", 64'(count_o), 64'd1);
        idle(1'b1);
        checkOutput("single popped count", 64'(count_o), 64'd0);
        checkOutput("single popped valid", 64'(out_valid_o), 64'd0);
        checkOutput("empty pc reads 0", 64'(out_pc_o), 64'd0);
        idle(1'b1);
        checkOutput("empty pop ignored", 64'(count_o), 64'd0);

        // Compaction of lanes 1 and 3
        doReset();
        applyStimulus(4'b1010, {32'h10C, 32'h0, 32'h104, 32'h0}, 1'b0, 1'b0);
        checkOutput("compact count", 64'(count_o), 64'd2);
        checkOutput("compact pc0", 64'(out_pc_o), 64'h104);
        checkOutput("compact seq0", 64'(out_seq_o), 64'd0);
        idle(1'b1);
        checkOutput("compact pc1", 64'(out_pc_o), 64'h10C);
        checkOutput("compact seq1", 64'(out_seq_o), 64'd1);
        idle(1'b0);
        checkOutput("stall pc stable", 64'(out_pc_o), 64'h10C);
        checkOutput("stall seq stable", 64'(out_seq_o), 64'd1);
        idle(1'b1);
        checkOutput("compact drained", 64'(count_o), 64'd0);

        // Fill, overflow, ordered drain across the wrap, seq gap
        doReset();
        for (int g = 0; g < 4; g++) fillGroup(g);
        checkOutput("fill count", 64'(count_o), 64'd16);
        checkOutput("fill no overflow", 64'(overflow_o), 64'd0);
        applyStimulus(4'b0011, {64'h0, 32'h5004, 32'h5000}, 1'b0, 1'b0);
        checkOutput("ovf flag", 64'(overflow_o), 64'd1);
        checkOutput("ovf drops", 64'(drop_count_o), 64'd2);
        checkOutput("ovf count", 64'(count_o), 64'd16);
        for (int k = 0; k < 16; k++) begin
            checkOutput($sformatf("drain seq%0d", k), 64'(out_seq_o), 64'(k));
            checkOutput($sformatf("drain pc%0d", k), 64'(out_pc_o), 64'(32'h1000 + 4*k));
            idle(1'b1);
        end
        checkOutput("drain count", 64'(count_o), 64'd0);
        applyStimulus(4'b0001, {96'h0, 32'h2000}, 1'b0, 1'b0);
        checkOutput("post-gap seq", 64'(out_seq_o), 64'd18);
        checkOutput("post-gap pc", 64'(out_pc_o), 64'h2000);
        idle(1'b1);

        // Full with simultaneous pop: push still dropped
        for (int g = 0; g < 4; g++) fillGroup(g);
        checkOutput("refill count", 64'(count_o), 64'd16);
        applyStimulus(4'b0001, {96'h0, 32'h6000}, 1'b0, 1'b1);
        checkOutput("full+pop count", 64'(count_o), 64'd15);
        checkOutput("full+pop drops", 64'(drop_count_o), 64'd3);
        checkOutput("full+pop head seq", 64'(out_seq_o), 64'd20);

        // Halt with same-cycle retire, later retires ignored, done after drain
        doReset();
        applyStimulus(4'b0111, {32'h0, 32'h208, 32'h204, 32'h200}, 1'b0, 1'b0);
        checkOutput("halt pre count", 64'(count_o), 64'd3);
        applyStimulus(4'b0001, {96'h0, 32'h300}, 1'b1, 1'b0);
        checkOutput("halt accept count", 64'(count_o), 64'd4);
        applyStimulus(4'b1111, {32'h40C, 32'h408, 32'h404, 32'h400}, 1'b0, 1'b0);
        checkOutput("post-halt count", 64'(count_o), 64'd4);
        checkOutput("post-halt drops", 64'(drop_count_o), 64'd0);
        checkOutput("post-halt overflow", 64'(overflow_o), 64'd0);
        checkOutput("done while busy", 64'(done_o), 64'd0);
        for (int k = 0; k < 3; k++) idle(1'b1);
        checkOutput("halt last pc", 64'(out_pc_o), 64'h300);
        checkOutput("halt last seq", 64'(out_seq_o), 64'd3);
        idle(1'b1);
        checkOutput("halt drained", 64'(count_o), 64'd0);
        checkOutput("done not yet", 64'(done_o), 64'd0);
        idle(1'b0);
        checkOutput("done rises", 64'(done_o), 64'd1);
        idle(1'b0);
        checkOutput("done sticky", 64'(done_o), 64'd1);

        // Async reset in the middle of a cycle
        doReset();
        for (int g = 0; g < 4; g++) fillGroup(g);
        applyStimulus(4'b0001, {96'h0, 32'h7000}, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) idle(1'b1);
        checkOutput("pre-reset count", 64'(count_o), 64'd7);
        checkOutput("pre-reset overflow", 64'(overflow_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("async count", 64'(count_o), 64'd0);
        checkOutput("async valid", 64'(out_valid_o), 64'd0);
        checkOutput("async overflow", 64'(overflow_o), 64'd0);
        checkOutput("async drops", 64'(drop_count_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        applyStimulus(4'b0001, {96'h0, 32'h400}, 1'b0, 1'b0);
        checkOutput("restart seq", 64'(out_seq_o), 64'd0);
        checkOutput("restart pc", 64'(out_pc_o), 64'h400);
        checkOutput("restart count", 64'(count_o), 64'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/coralnpu_cosim_retire_buffer.md
Name: coralnpu_cosim_retire_buffer

Overview:
- Multi-lane retirement capture buffer between the DUT retire ports and the MPACT cosim stepping driver.
- Each cycle it accepts up to NUM_RETIRE retired instructions and compacts them in program order.
- It buffers them in a circular FIFO and presents them one per handshake to the driver, which steps MPACT and compares.
- It adds sequence numbering, overflow detection and halt/drain tracking.

Parameters:
NUM_RETIRE, 4, retire lanes per cycle (1..8); lane 0 is oldest
DEPTH, 16, FIFO entries; power of two, must be >= NUM_RETIRE
XLEN, 32, width of pc and instruction fields
SEQ_W, 32, sequence counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
retire_valid_i  in  NUM_RETIRE  per-lane retire valid
retire_pc_i  in  NUM_RETIRE*XLEN  per-lane PC, lane i at [i*XLEN +: XLEN]
retire_insn_i  in  NUM_RETIRE*XLEN  per-lane instruction word
halt_i  in  1  DUT halted; no further retires follow
out_valid_o  out  1  head entry available
out_ready_i  in  1  driver consumes head
out_pc_o  out  XLEN  head PC
out_insn_o  out  XLEN  head instruction
out_seq_o  out  SEQ_W  head sequence number
count_o  out  $clog2(DEPTH)+1  current occupancy
overflow_o  out  1  sticky: a retire group was dropped
drop_count_o  out  16  saturating count of dropped instructions
done_o  out  1  halt seen and FIFO drained

Behaviour:
- Reset (async assert, sync release): wr/rd pointers 0, count_o 0, out_valid_o 0, overflow_o 0, drop_count_o 0, seq counter 0, halt latch 0, done_o 0. out_pc_o, out_insn_o and out_seq_o read 0 while empty.
- Reset mid-operation discards all entries immediately. No partial state survives.
- Compaction: the set lanes of retire_valid_i are packed in ascending lane order. Gaps are allowed. Example: valid=4'b1010 writes lane1 then lane3 into consecutive slots.
- n_in = popcount(retire_valid_i). free = DEPTH - count, evaluated before this cycle's pop; a same-cycle pop is not credited.
- If n_in <= free: all n_in entries are written at wr_ptr..wr_ptr+n_in-1 (mod DEPTH). Each is tagged with seq, seq+1, ..., and seq advances by n_in. Wrap-around is modulo DEPTH. seq wraps modulo 2^SEQ_W.
- If n_in > free: the whole group is dropped, with no partial write. overflow_o is set (sticky until reset). drop_count_o += n_in, saturating at 0xFFFF. seq still advances by n_in so gaps are visible to the driver.
- Output: out_valid_o = (count != 0). Head fields are driven combinationally from the rd_ptr slot. A pop occurs when out_valid_o && out_ready_i, and rd_ptr advances by 1.
- Latency: an entry written at edge N is visible on out_* after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop: count_next = count + n_written - pop.
- Full: free = 0, so any n_in > 0 is dropped, even if a pop occurs in the same cycle.
- Empty: out_ready_i is ignored; no pointer change.
- Halt: halt_i sets a sticky latch. Retires arriving in the same cycle as halt_i are still accepted. Retires after the latch is set are ignored, and are not counted as drops.
- done_o is registered: it asserts the cycle after (halt latch && count==0 && no write pending). It stays high until reset.
- Head fields are stable while out_valid_o && !out_ready_i.

Test Plan:
- Single lane: NUM_RETIRE=4; one cycle valid=4'b0001, pc=0x80000000, insn=0x00000013 -> next cycle out_valid_o=1, out_pc_o=0x80000000, out_seq_o=0; pop -> count_o=0.
- Compaction: valid=4'b1010, lane1 pc=0x104, lane3 pc=0x10C -> pops yield pc 0x104 (seq 0) then 0x10C (seq 1).
- Wrap and backpressure: DEPTH=16, out_ready_i=0; push 4 per cycle for 4 cycles -> count_o=16. Fifth group of 2 -> overflow_o=1, drop_count_o=2, count_o=16. Drain all -> seq 0..15 in order; next accepted entry carries seq 18.
- Full plus pop: count_o=16, same cycle pop and valid=4'b0001 -> group dropped, count_o=15, drop_count_o=1.
- Halt/drain: 3 entries queued, halt_i pulse with valid=4'b0001 -> 4 entries accepted; later retire ignored (drop_count_o unchanged); done_o rises 1 cycle after the 4th pop.
- Async reset mid-stream: rst_ni low while count_o=7 -> immediately count_o=0, out_valid_o=0, overflow_o=0; after release, the first push gets seq 0.
